arcade_input_cond: RTL and testbench
====================================

# arcade_input_cond

Input conditioning stage that sits directly upstream of the `pacman` core's `in0`/`in1` ports. It merges PS/2 keyboard events and the combined MiSTer joystick word into two registered active-low input bytes. Each player gets per-player 4-way direction arbitration with optional 90° rotation remap. Each coin input gets a pulse-shaping FSM so the core sees one clean, fixed-length coin pulse per press.

## Interface
Parameters:
- `COIN_PULSE`, default 24'd2_400_000: coin-low duration in `clk_sys` cycles (about 100 ms at 24 MHz); minimum 1.
- `COIN_GAP`, default 24'd2_400_000: lockout after each pulse, in cycles; 0 is allowed.

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_key`  in  11  [10] toggles once per key event, [9] pressed, [8] extended, [7:0] scancode.
- `joy`  in  8  active-high joystick: [0] R, [1] L, [2] D, [3] U, [4] skip, [5] start1, [6] start2, [7] coin.
- `rotate`  in  1  1 = horizontal orientation; remap directions.
- `cabinet`  in  1  1 = cocktail; drives `in1[7]`.
- `in0`  out  8  active-low: [0] U1, [1] L1, [2] R1, [3] D1, [4] skip, [5] coin1, [6] coin2, [7] 1 (const).
- `in1`  out  8  active-low: [0] U2, [1] L2, [2] R2, [3] D2, [4] 1 (const), [5] start1, [6] start2, [7] = ~`cabinet`.

## Operation
- **Key capture.** `tgl_q` registers `ps2_key[10]` every edge. An event occurs when `ps2_key[10] != tgl_q`. On an event, the matching key register is loaded with `ps2_key[9]` on the same edge. Extended bit ignored except for the arrow keys, which are matched on code only.
- **Key map.**
  - P1 directions: 75 up, 72 down, 6B left, 74 right.
  - Skip: 29 (space), 14 (ctrl), 1C (A).
  - Starts and coins: 05 (F1) start1, 06 (F2) start2, 04 (F3) coin1, 16 (1) start1, 1E (2) start2, 2E (5) coin1, 36 (6) coin2.
  - P2 directions: 2D up, 2B down, 23 left, 34 right.
  - Unmapped codes are ignored.
- **Raw requests.** Each raw request is the key OR the corresponding `joy` bit. P2 directions also OR in the joystick directions, as P1 does.
- **Rotation.** When `rotate`=1, raw {U,D,L,R} becomes {L,R,D,U}.
- **4-way arbitration (per player).**
  - `cur` registers the raw directions; `cur_d` registers `cur`.
  - `new = cur & ~cur_d`. If several bits of `new` are set, the highest index wins (R>L>D>U).
  - `mask` loads a one-hot of the winner.
  - Direction output = `cur_d & mask`, so at most one direction is ever active.
  - `mask` reset = 0, meaning no direction until the first fresh press.
- **Coin FSM (one per coin).**
  - States: IDLE, PULSE, GAP. A 24-bit counter.
  - IDLE: a rising edge of the coin request (`cur & ~cur_d`) → PULSE with cnt = COIN_PULSE-1; the coin bit is driven low.
  - PULSE: decrement; at cnt==0 → GAP with cnt = COIN_GAP-1, or → IDLE if COIN_GAP==0.
  - GAP: decrement; at cnt==0 → IDLE.
  - Presses during PULSE or GAP are dropped, not queued. Holding the coin produces exactly one pulse.
- **Other buttons.** Skip and starts pass through the `cur`/`cur_d` pipeline without arbitration.
- **Reset.** While `reset_n`=0: `in0`=8'hFF, `in1`=8'hFF, all key registers 0, masks 0, coin FSMs IDLE, `tgl_q`=0. Reset mid-pulse aborts the pulse immediately; no pulse resumes after release.

## Timing
- **Pipeline.** Let E0 be the edge that captures a key event. Then `cur` updates at E0+1, `cur_d` and `mask` at E0+2, and the output registers at E0+3. Press and release therefore both take 3 edges.
- **Joystick path.** A `joy` change sampled at edge E appears at the outputs at E+2.
- **Coin pulse.** The coin bit falls in the same cycle that buttons would appear (the PULSE state is registered into the output at E0+3). It stays low for exactly COIN_PULSE cycles.
- **Outputs.** All outputs are registered; there is no combinational path from input to output.
- **`cabinet`.** Sampled every edge; reaches `in1[7]` one edge later.

## Test plan
- **Reset values.** Hold `reset_n`=0 with `joy`=8'hFF → `in0`=8'hFF, `in1`=8'hFF. Release → still 8'hFF until the first fresh press.
- **Keyboard left.** Toggle `ps2_key` with {1,0,6B} → `in0`=8'hFD three edges later. Release event → `in0`=8'hFF three edges later.
- **4-way arbitration.** Hold `joy[3]` (up), then add `joy[0]` (right) → `in0` goes 8'hFE then 8'hFB. Drop right while up is still held → `in0`=8'hFF, since the mask stays on right.
- **Rotation.** With `rotate`=1, press up → `in0[1]` (L1) low; all other direction bits high.
- **Coin pulse and lockout.** With COIN_PULSE=4 and COIN_GAP=3: hold `joy[7]` for 20 cycles → `in0[6]` low for exactly 4 cycles, once. Re-press 2 cycles after the pulse ends (inside GAP) → no pulse. Press after the gap → a second pulse.
- **Reset mid-pulse.** Assert `reset_n`=0 in the 2nd cycle of PULSE → `in0[6]`=1 immediately, FSM IDLE. After release with coin still held → no pulse until coin is released and pressed again.

Source files
------------

// File: rtl/arcade_input_cond_if.sv
// arcade_input_cond_if
//   Signal bundle between the input sources (PS/2 keyboard, MiSTer joystick
//   word, orientation/cabinet switches) and the arcade_input_cond stage.
//
//   Handshake: there is no valid/ready pair on this bus. ps2_key[10] is the
//   only event qualifier; every change of that bit marks one key event
//   described by ps2_key[9:0]. All other inputs are level signals sampled on
//   every clock edge. Outputs are registered levels.
//
//   Signals:
//     ps2_key      [10] toggle per event, [9] pressed, [8] extended, [7:0] code
//     joy          active-high {coin, start2, start1, skip, U, D, L, R}
//     rotate       1 = horizontal orientation, directions remapped
//     cabinet      1 = cocktail cabinet
//     in0, in1     active-low input bytes for the core
//     coin1_state  debug view of the coin 1 pulse FSM (0 idle, 1 pulse, 2 gap)
//     coin2_state  debug view of the coin 2 pulse FSM
interface arcade_input_cond_if;
  logic [10:0] ps2_key;
  logic [7:0]  joy;
  logic        rotate;
  logic        cabinet;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic [1:0]  coin1_state;
  logic [1:0]  coin2_state;

  modport master (
    output ps2_key, joy, rotate, cabinet,
    input  in0, in1, coin1_state, coin2_state
  );

  modport slave (
    input  ps2_key, joy, rotate, cabinet,
    output in0, in1, coin1_state, coin2_state
  );
endinterface

// File: rtl/arcade_input_cond.sv
// arcade_input_cond
//   Merges PS/2 key events and the MiSTer joystick word into the two
//   active-low input bytes of the pacman core. Per player: 4-way direction
//   arbitration (last fresh press wins) with optional 90 degree remap. Per
//   coin: a pulse FSM producing one fixed-length low pulse per press followed
//   by a lockout gap.
//
//   Ports:
//     clk_sys   system clock
//     reset_n   asynchronous active-low reset
//     bus       arcade_input_cond_if slave modport (inputs, in0/in1, debug)
//
//   Parameters:
//     COIN_PULSE  coin-low length in clk_sys cycles (>= 1)
//     COIN_GAP    lockout after each pulse in cycles (0 allowed)
module arcade_input_cond #(
  parameter logic [23:0] COIN_PULSE = 24'd2_400_000,
  parameter logic [23:0] COIN_GAP   = 24'd2_400_000
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  arcade_input_cond_if.slave bus
);

  // Key register indices, one per mapped scancode.
  localparam int K_U1 = 0,  K_D1 = 1,  K_L1 = 2,  K_R1 = 3;
  localparam int K_SPC = 4, K_CTL = 5, K_A = 6;
  localparam int K_F1 = 7,  K_F2 = 8,  K_F3 = 9;
  localparam int K_1 = 10,  K_2 = 11,  K_5 = 12,  K_6 = 13;
  localparam int K_U2 = 14, K_D2 = 15, K_L2 = 16, K_R2 = 17;

  // Request vector: [3:0] P1 {R,L,D,U}, [7:4] P2 {R,L,D,U},
  // [8] skip, [9] start1, [10] start2, [11] coin1, [12] coin2.
  localparam int R_SKIP = 8, R_ST1 = 9, R_ST2 = 10, R_C1 = 11, R_C2 = 12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } coin_state_e;

  // Horizontal orientation: up->left, down->right, left->down, right->up.
  function automatic logic [3:0] rot_dir(input logic [3:0] d, input logic en);
    return en ? {d[1], d[0], d[2], d[3]} : d;
  endfunction

  // Highest index wins: R > L > D > U.
  function automatic logic [3:0] pick_winner(input logic [3:0] f);
    logic [3:0] w;
    w = 4'b0000;
    if (f[3])      w = 4'b1000;
    else if (f[2]) w = 4'b0100;
    else if (f[1]) w = 4'b0010;
    else if (f[0]) w = 4'b0001;
    return w;
  endfunction

  logic        tgl_q;
  logic        key_event;
  logic [17:0] key_q;
  logic [17:0] key_hit;
  logic [3:0]  joy_dir;
  logic [3:0]  p1_raw;
  logic [3:0]  p2_raw;
  logic [12:0] raw;
  logic [12:0] cur;
  logic [12:0] cur_d;
  logic [12:0] fresh;
  logic [3:0]  mask1_q;
  logic [3:0]  mask2_q;
  logic [3:0]  dir1;
  logic [3:0]  dir2;
  logic [7:0]  in0_q;
  logic [7:0]  in1_q;
  logic        unused_ext;

  coin_state_e state_q [2];
  coin_state_e state_d [2];
  logic [23:0] cnt_q   [2];
  logic [23:0] cnt_d   [2];
  logic [1:0]  coin_rise;
  logic [1:0]  coin_low;

  // Extended flag carries no information for this map: arrows match on code.
  assign unused_ext = bus.ps2_key[8];
  assign key_event  = bus.ps2_key[10] ^ tgl_q;

  always_comb begin
    key_hit = '0;
    case (bus.ps2_key[7:0])
      8'h75: key_hit[K_U1]  = 1'b1;
      8'h72: key_hit[K_D1]  = 1'b1;
      8'h6B: key_hit[K_L1]  = 1'b1;
      8'h74: key_hit[K_R1]  = 1'b1;
      8'h29: key_hit[K_SPC] = 1'b1;
      8'h14: key_hit[K_CTL] = 1'b1;
      8'h1C: key_hit[K_A]   = 1'b1;
      8'h05: key_hit[K_F1]  = 1'b1;
      8'h06: key_hit[K_F2]  = 1'b1;
      8'h04: key_hit[K_F3]  = 1'b1;
      8'h16: key_hit[K_1]   = 1'b1;
      8'h1E: key_hit[K_2]   = 1'b1;
      8'h2E: key_hit[K_5]   = 1'b1;
      8'h36: key_hit[K_6]   = 1'b1;
      8'h2D: key_hit[K_U2]  = 1'b1;
      8'h2B: key_hit[K_D2]  = 1'b1;
      8'h23: key_hit[K_L2]  = 1'b1;
      8'h34: key_hit[K_R2]  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tgl_q <= 1'b0;
      key_q <= '0;
    end else begin
      tgl_q <= bus.ps2_key[10];
      if (key_event)
        key_q <= (key_q & ~key_hit) | (key_hit & {18{bus.ps2_key[9]}});
    end
  end

  // Joystick directions feed both players, reordered to {R,L,D,U}.
  assign joy_dir = {bus.joy[0], bus.joy[1], bus.joy[2], bus.joy[3]};
  assign p1_raw  = rot_dir({key_q[K_R1], key_q[K_L1], key_q[K_D1], key_q[K_U1]} | joy_dir,
                           bus.rotate);
  assign p2_raw  = rot_dir({key_q[K_R2], key_q[K_L2], key_q[K_D2], key_q[K_U2]} | joy_dir,
                           bus.rotate);

  // The joystick coin bit drives coin 2 (in0[6]); coin 1 is keyboard only.
  assign raw = {key_q[K_6] | bus.joy[7],
                key_q[K_F3] | key_q[K_5],
                key_q[K_F2] | key_q[K_2] | bus.joy[6],
                key_q[K_F1] | key_q[K_1] | bus.joy[5],
                key_q[K_SPC] | key_q[K_CTL] | key_q[K_A] | bus.joy[4],
                p2_raw, p1_raw};

  // cur/cur_d keep sampling during reset on purpose: a button held across
  // reset is then not seen as a fresh press, so no coin pulse or direction
  // arms itself on release.
  always_ff @(posedge clk_sys) begin
    cur   <= raw;
    cur_d <= cur;
  end

  assign fresh = cur & ~cur_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mask1_q <= 4'b0000;
      mask2_q <= 4'b0000;
    end else begin
      if (|fresh[3:0]) mask1_q <= pick_winner(fresh[3:0]);
      if (|fresh[7:4]) mask2_q <= pick_winner(fresh[7:4]);
    end
  end

  assign dir1      = cur_d[3:0] & mask1_q;
  assign dir2      = cur_d[7:4] & mask2_q;
  assign coin_rise = fresh[R_C2:R_C1];

  // Coin pulse FSMs: index 0 = coin1, 1 = coin2.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (coin_rise[i]) begin
            state_d[i] = S_PULSE;
            cnt_d[i]   = COIN_PULSE - 24'd1;
          end
        end
        S_PULSE: begin
          if (cnt_q[i] == 24'd0) begin
            if (COIN_GAP == 24'd0) begin
              state_d[i] = S_IDLE;
            end else begin
              state_d[i] = S_GAP;
              cnt_d[i]   = COIN_GAP - 24'd1;
            end
          end else begin
            cnt_d[i] = cnt_q[i] - 24'd1;
          end
        end
        S_GAP: begin
          if (cnt_q[i] == 24'd0) state_d[i] = S_IDLE;
          else                   cnt_d[i]   = cnt_q[i] - 24'd1;
        end
        default: state_d[i] = S_IDLE;
      endcase
      coin_low[i] = (state_q[i] == S_PULSE);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      in0_q <= 8'hFF;
      in1_q <= 8'hFF;
    end else begin
      in0_q <= {1'b1, ~coin_low[1], ~coin_low[0], ~cur_d[R_SKIP],
                ~dir1[1], ~dir1[3], ~dir1[2], ~dir1[0]};
      in1_q <= {~bus.cabinet, ~cur_d[R_ST2], ~cur_d[R_ST1], 1'b1,
                ~dir2[1], ~dir2[3], ~dir2[2], ~dir2[0]};
    end
  end

  assign bus.in0         = in0_q;
  assign bus.in1         = in1_q;
  assign bus.coin1_state = state_q[0];
  assign bus.coin2_state = state_q[1];

endmodule

// File: tb/tb_arcade_input_cond.sv
// tb_arcade_input_cond
//   Self-checking bench for arcade_input_cond with COIN_PULSE=4, COIN_GAP=3.
//   A request-level reference model tracks pressed keys, the most recent
//   fresh direction per player and coin pulse windows in absolute edge
//   numbers; directed scenarios add fixed expected bytes on top.
module tb_arcade_input_cond;
  localparam int P = 4;
  localparam int G = 3;
  localparam int W_NONE = 0, W_U = 1, W_D = 2, W_L = 3, W_R = 4;

  typedef struct packed { logic u; logic d; logic l; logic r; } dir_t;
  typedef struct packed {
    dir_t p1; dir_t p2;
    logic skip; logic start1; logic start2; logic coin1; logic coin2;
  } req_t;

  logic clk_sys;
  logic reset_n;
  logic ps2_tgl;
  int   n_checks;
  int   n_fail;

  arcade_input_cond_if bus ();

  arcade_input_cond #(.COIN_PULSE(24'd4), .COIN_GAP(24'd3)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // ---------------- reference model ----------------
  bit         key_down [256];
  logic       m_tgl;
  req_t       h1, h2;
  int         win1, win2, edge_n;
  int         c_from [2], c_to [2], c_busy [2];
  logic [7:0] exp_in0, exp_in1;

  function automatic dir_t orient(input dir_t p, input logic rot);
    dir_t o;
    if (!rot) return p;
    o.l = p.u; o.r = p.d; o.d = p.l; o.u = p.r;
    return o;
  endfunction

  function automatic req_t build_req();
    req_t q;
    dir_t j, a, b;
    j = '{u: bus.joy[3], d: bus.joy[2], l: bus.joy[1], r: bus.joy[0]};
    a = '{u: key_down[8'h75], d: key_down[8'h72], l: key_down[8'h6B], r: key_down[8'h74]};
    b = '{u: key_down[8'h2D], d: key_down[8'h2B], l: key_down[8'h23], r: key_down[8'h34]};
    q.p1     = orient(a | j, bus.rotate);
    q.p2     = orient(b | j, bus.rotate);
    q.skip   = key_down[8'h29] | key_down[8'h14] | key_down[8'h1C] | bus.joy[4];
    q.start1 = key_down[8'h05] | key_down[8'h16] | bus.joy[5];
    q.start2 = key_down[8'h06] | key_down[8'h1E] | bus.joy[6];
    q.coin1  = key_down[8'h04] | key_down[8'h2E];
    q.coin2  = key_down[8'h36] | bus.joy[7];
    return q;
  endfunction

  function automatic int next_winner(input int prev, input dir_t now, input dir_t old);
    if (now.r && !old.r) return W_R;
    if (now.l && !old.l) return W_L;
    if (now.d && !old.d) return W_D;
    if (now.u && !old.u) return W_U;
    return prev;
  endfunction

  // Active-low {D,R,L,U} as laid out in in0/in1 bits [3:0].
  function automatic logic [3:0] dir_bits(input dir_t held, input int win);
    logic [3:0] b;
    b = 4'hF;
    if (win == W_U && held.u) b[0] = 1'b0;
    if (win == W_L && held.l) b[1] = 1'b0;
    if (win == W_R && held.r) b[2] = 1'b0;
    if (win == W_D && held.d) b[3] = 1'b0;
    return b;
  endfunction

  initial begin
    m_tgl = 1'b0; h1 = '0; h2 = '0; win1 = W_NONE; win2 = W_NONE; edge_n = 0;
    exp_in0 = 8'hFF; exp_in1 = 8'hFF;
    for (int i = 0; i < 2; i++) begin c_from[i] = 0; c_to[i] = -1; c_busy[i] = 0; end
    for (int i = 0; i < 256; i++) key_down[i] = 1'b0;
  end

  // Output after edge n: the request seen two edges earlier, filtered by that
  // player's latest fresh direction; coin low inside its pulse window.
  always @(posedge clk_sys) begin
    edge_n++;
    if (!reset_n) begin
      exp_in0 = 8'hFF; exp_in1 = 8'hFF; win1 = W_NONE; win2 = W_NONE;
      for (int i = 0; i < 2; i++) begin c_to[i] = -1; c_busy[i] = 0; end
    end else begin
      exp_in0 = {1'b1, !(edge_n >= c_from[1] && edge_n <= c_to[1]),
                 !(edge_n >= c_from[0] && edge_n <= c_to[0]), !h2.skip,
                 dir_bits(h2.p1, win1)};
      exp_in1 = {!bus.cabinet, !h2.start2, !h2.start1, 1'b1, dir_bits(h2.p2, win2)};
      win1 = next_winner(win1, h1.p1, h2.p1);
      win2 = next_winner(win2, h1.p2, h2.p2);
      if (h1.coin1 && !h2.coin1 && edge_n >= c_busy[0]) begin
        c_from[0] = edge_n + 1; c_to[0] = edge_n + P; c_busy[0] = edge_n + P + G + 1;
      end
      if (h1.coin2 && !h2.coin2 && edge_n >= c_busy[1]) begin
        c_from[1] = edge_n + 1; c_to[1] = edge_n + P; c_busy[1] = edge_n + P + G + 1;
      end
    end
    h2 = h1;
    h1 = build_req();
    if (!reset_n) begin
      m_tgl = 1'b0;
      for (int i = 0; i < 256; i++) key_down[i] = 1'b0;
    end else begin
      if (bus.ps2_key[10] != m_tgl) key_down[bus.ps2_key[7:0]] = bus.ps2_key[9];
      m_tgl = bus.ps2_key[10];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_key(input logic [7:0] code, input logic pressed, input logic ext);
    ps2_tgl     = ~ps2_tgl;
    bus.ps2_key = {ps2_tgl, pressed, ext, code};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.joy = 8'hFF;
    repeat (4) begin
      @(negedge clk_sys);
      n_checks++;
      if (bus.in0 !== 8'hFF || bus.in1 !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset_hold: in0=%h in1=%h expected ff ff", bus.in0, bus.in1);
      end
    end
    bus.joy = 8'h00;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk_sys);
      n_checks++;
      if (bus.in0 !== 8'hFF || bus.in1 !== 8'hFF || bus.in0 !== exp_in0 || bus.in1 !== exp_in1) begin
        n_fail++;
        $display("FAIL reset_release: in0=%h in1=%h expected ff ff", bus.in0, bus.in1);
      end
    end
  endtask

  task automatic test_key_left();
    logic [7:0] want [4];
    want = '{8'hFF, 8'hFF, 8'hFF, 8'hFD};
    send_key(8'h6B, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      n_checks++;
      if (bus.in0 !== want[i] || bus.in0 !== exp_in0) begin
        n_fail++;
        $display("FAIL key_left_press[%0d]: in0=%h expected %h", i, bus.in0, want[i]);
      end
    end
    want = '{8'hFD, 8'hFD, 8'hFD, 8'hFF};
    send_key(8'h6B, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      n_checks++;
      if (bus.in0 !== want[i] || bus.in0 !== exp_in0) begin
        n_fail++;
        $display("FAIL key_left_release[%0d]: in0=%h expected %h", i, bus.in0, want[i]);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [7:0] joys [4];
    logic [7:0] want [4];
    joys = '{8'h08, 8'h09, 8'h08, 8'h00};
    want = '{8'hFE, 8'hFB, 8'hFF, 8'hFF};
    for (int s = 0; s < 4; s++) begin
      bus.joy = joys[s];
      repeat (3) @(negedge clk_sys);
      n_checks++;
      if (bus.in0 !== want[s] || bus.in0 !== exp_in0 || bus.in1 !== exp_in1) begin
        n_fail++;
        $display("FAIL arbitration[%0d]: in0=%h in1=%h expected in0=%h", s, bus.in0, bus.in1, want[s]);
      end
    end
  endtask

  task automatic test_rotation();
    bus.rotate = 1'b1;
    @(negedge clk_sys);
    bus.joy = 8'h08;
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if (bus.in0 !== 8'hFD || bus.in0 !== exp_in0) begin
      n_fail++;
      $display("FAIL rotation_up: in0=%h expected fd", bus.in0);
    end
    bus.joy = 8'h00;
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if (bus.in0 !== 8'hFF || bus.in0 !== exp_in0) begin
      n_fail++;
      $display("FAIL rotation_release: in0=%h expected ff", bus.in0);
    end
    bus.rotate = 1'b0;
  endtask

  task automatic test_back_to_back();
    send_key(8'h6B, 1'b1, 1'b1);
    @(negedge clk_sys);
    send_key(8'h74, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      n_checks++;
      if (bus.in0 !== exp_in0 || bus.in1 !== exp_in1) begin
        n_fail++;
        $display("FAIL b2b_model[%0d]: in0=%h in1=%h expected %h %h", i, bus.in0, bus.in1, exp_in0, exp_in1);
      end
    end
    n_checks++;
    if (bus.in0 !== 8'hFB) begin
      n_fail++;
      $display("FAIL b2b_last_wins: in0=%h expected fb", bus.in0);
    end
    send_key(8'h6B, 1'b0, 1'b1);
    @(negedge clk_sys);
    send_key(8'h74, 1'b0, 1'b1);
    repeat (4) @(negedge clk_sys);
    n_checks++;
    if (bus.in0 !== 8'hFF || bus.in0 !== exp_in0) begin
      n_fail++;
      $display("FAIL b2b_release: in0=%h expected ff", bus.in0);
    end
  endtask

  task automatic test_cabinet();
    bus.cabinet = 1'b1;
    @(negedge clk_sys);
    n_checks++;
    if (bus.in1 !== 8'h7F || bus.in1 !== exp_in1) begin
      n_fail++;
      $display("FAIL cabinet_on: in1=%h expected 7f", bus.in1);
    end
    bus.cabinet = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (bus.in1 !== 8'hFF || bus.in1 !== exp_in1) begin
      n_fail++;
      $display("FAIL cabinet_off: in1=%h expected ff", bus.in1);
    end
  endtask

  task automatic test_coin();
    int  low_cnt;
    bit  seen;
    low_cnt = 0;
    bus.joy = 8'h80;
    for (int i = 0; i < 24; i++) begin
      if (i == 20) bus.joy = 8'h00;
      @(negedge clk_sys);
      n_checks++;
      if (bus.in0 !== exp_in0) begin
        n_fail++;
        $display("FAIL coin_hold[%0d]: in0=%h expected %h", i, bus.in0, exp_in0);
      end
      if (bus.in0[6] === 1'b0) low_cnt++;
    end
    n_checks++;
    if (low_cnt !== P) begin
      n_fail++;
      $display("FAIL coin_pulse_len: low cycles=%0d expected %0d", low_cnt, P);
    end
    // Single-cycle press; re-press the moment the pulse ends (inside the gap).
    bus.joy = 8'h80;
    @(negedge clk_sys);
    bus.joy = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_sys);
      if (bus.in0[6] === 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL coin_start_timeout: in0[6]=%b expected 0 within 10 cycles", bus.in0[6]);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_sys);
      if (bus.in0[6] === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL coin_end_timeout: in0[6]=%b expected 1 within 10 cycles", bus.in0[6]);
    end
    bus.joy = 8'h80;
    @(negedge clk_sys);
    bus.joy = 8'h00;
    low_cnt = 0;
    repeat (12) begin
      @(negedge clk_sys);
      n_checks++;
      if (bus.in0 !== exp_in0) begin
        n_fail++;
        $display("FAIL coin_gap_model: in0=%h expected %h", bus.in0, exp_in0);
      end
      if (bus.in0[6] === 1'b0) low_cnt++;
    end
    n_checks++;
    if (low_cnt !== 0) begin
      n_fail++;
      $display("FAIL coin_gap_drop: low cycles=%0d expected 0", low_cnt);
    end
    bus.joy = 8'h80;
    @(negedge clk_sys);
    bus.joy = 8'h00;
    low_cnt = 0;
    repeat (10) begin
      @(negedge clk_sys);
      n_checks++;
      if (bus.in0 !== exp_in0) begin
        n_fail++;
        $display("FAIL coin_after_gap_model: in0=%h expected %h", bus.in0, exp_in0);
      end
      if (bus.in0[6] === 1'b0) low_cnt++;
    end
    n_checks++;
    if (low_cnt !== P) begin
      n_fail++;
      $display("FAIL coin_after_gap: low cycles=%0d expected %0d", low_cnt, P);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int low_cnt;
    bit seen;
    bus.joy = 8'h80;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_sys);
      if (bus.in0[6] === 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_pulse_timeout: in0[6]=%b expected 0 within 10 cycles", bus.in0[6]);
    end
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in0 !== 8'hFF || bus.in1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL rst_async: in0=%h in1=%h expected ff ff", bus.in0, bus.in1);
    end
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    low_cnt = 0;
    repeat (15) begin
      @(negedge clk_sys);
      n_checks++;
      if (bus.in0 !== exp_in0) begin
        n_fail++;
        $display("FAIL rst_held_model: in0=%h expected %h", bus.in0, exp_in0);
      end
      if (bus.in0[6] === 1'b0) low_cnt++;
    end
    n_checks++;
    if (low_cnt !== 0) begin
      n_fail++;
      $display("FAIL rst_no_resume: low cycles=%0d expected 0", low_cnt);
    end
    bus.joy = 8'h00;
    repeat (3) @(negedge clk_sys);
    bus.joy = 8'h80;
    low_cnt = 0;
    repeat (10) begin
      @(negedge clk_sys);
      if (bus.in0[6] === 1'b0) low_cnt++;
    end
    n_checks++;
    if (low_cnt !== P) begin
      n_fail++;
      $display("FAIL rst_repress: low cycles=%0d expected %0d", low_cnt, P);
    end
    bus.joy = 8'h00;
    repeat (8) @(negedge clk_sys);
  endtask

  task automatic test_random();
    logic [7:0] codes [22];
    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h1C, 8'h05, 8'h06, 8'h04, 8'h16,
              8'h1E, 8'h2E, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h11, 8'h5A, 8'h00, 8'hF0};
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_sys);
      n_checks++;
      if (bus.in0 !== exp_in0 || bus.in1 !== exp_in1) begin
        n_fail++;
        $display("FAIL random[%0d]: in0=%h in1=%h expected %h %h", c, bus.in0, bus.in1, exp_in0, exp_in1);
      end
      if ($urandom_range(3, 0) == 0) bus.joy[$urandom_range(7, 0)] = ~bus.joy[$urandom_range(7, 0)];
      if ($urandom_range(2, 0) == 0)
        send_key(codes[$urandom_range(21, 0)], 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      if ($urandom_range(39, 0) == 0) bus.rotate = ~bus.rotate;
      if ($urandom_range(29, 0) == 0) bus.cabinet = ~bus.cabinet;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    ps2_tgl     = 1'b0;
    bus.ps2_key = 11'h000;
    bus.joy     = 8'h00;
    bus.rotate  = 1'b0;
    bus.cabinet = 1'b0;
    test_reset();
    test_key_left();
    test_arbitration();
    test_rotation();
    test_back_to_back();
    test_cabinet();
    test_coin();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
